imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 129 ++++++++++++
 tb/tb_imm_encoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage RV32I instruction encoder with range checking and saturating handshake counters.
module imm_encoder (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        cnt_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] inst_count,
    output logic [15:0] err_count
);
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011, OP_JALR = 7'b1100111,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111, OP_OP = 7'b0110011;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic signed [31:0] imm_s;
    logic               in_ok, s2_load, hs;
    logic               s1_valid_q, s1_ok_q;
    logic [6:0]         s1_op_q, s1_f7_q;
    logic [4:0]         s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]         s1_f3_q;
    logic [31:0]        s1_imm_q;
    logic               out_valid_q, out_err_q, out_err_d;
    logic [31:0]        out_inst_q, out_inst_d;
    logic [15:0]        inst_cnt_q, inst_cnt_d, err_cnt_q, err_cnt_d;

    assign imm_s     = in_imm;
    assign s2_load   = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load;
    assign hs        = out_valid_q && out_ready;

    // Range check runs on the full signed word so large values cannot alias into range.
    always_comb begin
        in_ok = 1'b0;
        case (in_opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_STORE: in_ok = imm_s >= -32'sd2048 && imm_s <= 32'sd2047;
            OP_BRANCH: in_ok = imm_s >= -32'sd4096 && imm_s <= 32'sd4094 && !in_imm[0];
            OP_JAL:    in_ok = imm_s >= -32'sd1048576 && imm_s <= 32'sd1048574 && !in_imm[0];
            OP_AUIPC, OP_LUI: in_ok = in_imm[11:0] == 12'd0;
            OP_OP:     in_ok = 1'b1;
            default:   in_ok = 1'b0;
        endcase
    end

    always_comb begin
        out_inst_d = NOP;
        out_err_d  = !s1_ok_q;
        if (s1_ok_q) begin
            case (s1_op_q)
                OP_LOAD, OP_IMM, OP_JALR:
                    out_inst_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
                OP_STORE:
                    out_inst_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
                OP_BRANCH:
                    out_inst_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                                  s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
                OP_JAL:
                    out_inst_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q, s1_op_q};
                OP_AUIPC, OP_LUI:
                    out_inst_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
                OP_OP:
                    out_inst_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
                default: out_inst_d = NOP;
            endcase
        end
    end

    assign inst_cnt_d = cnt_clr ? 16'd0 : (hs && inst_cnt_q != 16'hFFFF) ? inst_cnt_q + 16'd1 : inst_cnt_q;
    assign err_cnt_d  = cnt_clr ? 16'd0 : (hs && out_err_q && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_ok_q     <= 1'b0;
            s1_op_q     <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_f3_q     <= '0;
            s1_f7_q     <= '0;
            s1_imm_q    <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_err_q   <= 1'b0;
            inst_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_ok_q  <= in_ok;
                    s1_op_q  <= in_opcode;
                    s1_rd_q  <= in_rd;
                    s1_rs1_q <= in_rs1;
                    s1_rs2_q <= in_rs2;
                    s1_f3_q  <= in_funct3;
                    s1_f7_q  <= in_funct7;
                    s1_imm_q <= in_imm;
                end
            end
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_inst_q <= out_inst_d;
                    out_err_q  <= out_err_d;
                end
            end
            inst_cnt_q <= inst_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_inst   = out_inst_q;
    assign out_err    = out_err_q;
    assign inst_count = inst_cnt_q;
    assign err_count  = err_cnt_q;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed-vector bench for imm_encoder with immediate-assertion checks.
module tb_imm_encoder;
    logic        clk, rstn, in_valid, in_ready, cnt_clr, out_valid, out_ready, out_err;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm, out_inst;
    logic [15:0] inst_count, err_count;
    int          checks = 0, errors = 0;

    imm_encoder dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
        .inst_count(inst_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    endtask

    // Called on a negedge; returns on the negedge after the output handshake.
    task automatic one(input string tag, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] exp_inst, input logic exp_err);
        req(op, rd, rs1, rs2, f3, f7, imm);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".inst"}, out_inst, exp_inst);
        chk({tag, ".err"}, 32'(out_err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        req(7'h13, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_inst", out_inst, 32'd0);
        chk("rst.out_err", 32'(out_err), 32'd0);
        chk("rst.inst_count", 32'(inst_count), 32'd0);
        chk("rst.err_count", 32'(err_count), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;

        one("addi5", 7'h13, 1, 0, 0, 0, 0, 32'd5, 32'h0050_0093, 1'b0);
        chk("cnt1.inst", 32'(inst_count), 32'd1);
        chk("cnt1.err", 32'(err_count), 32'd0);
        one("beq-4", 7'h63, 0, 0, 0, 0, 0, -32'sd4, 32'hFE00_0EE3, 1'b0);
        one("beq3", 7'h63, 0, 0, 0, 0, 0, 32'd3, 32'h0000_0013, 1'b1);
        chk("cnt2.inst", 32'(inst_count), 32'd3);
        chk("cnt2.err", 32'(err_count), 32'd1);
        one("jal2048", 7'h6F, 1, 0, 0, 0, 0, 32'd2048, 32'h0010_00EF, 1'b0);
        one("lui", 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        one("lui_bad", 7'h37, 5, 0, 0, 0, 0, 32'h1234_5001, 32'h0000_0013, 1'b1);
        one("addi2048", 7'h13, 0, 0, 0, 0, 0, 32'd2048, 32'h0000_0013, 1'b1);
        one("addi-2048", 7'h13, 0, 0, 0, 0, 0, -32'sd2048, 32'h8000_0013, 1'b0);
        one("addi_wide", 7'h13, 1, 0, 0, 0, 0, 32'h0001_0005, 32'h0000_0013, 1'b1);
        one("sub", 7'h33, 1, 2, 3, 0, 7'h20, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0);
        one("badop", 7'h7F, 1, 0, 0, 0, 0, 32'd0, 32'h0000_0013, 1'b1);
        one("sw", 7'h23, 0, 2, 3, 2, 0, 32'd8, 32'h0031_2423, 1'b0);
        one("beq4094", 7'h63, 0, 0, 0, 0, 0, 32'd4094, 32'h7E00_0FE3, 1'b0);
        one("beq4096", 7'h63, 0, 0, 0, 0, 0, 32'd4096, 32'h0000_0013, 1'b1);
        one("jal_odd", 7'h6F, 1, 0, 0, 0, 0, 32'd3, 32'h0000_0013, 1'b1);
        chk("cnt3.inst", 32'(inst_count), 32'd15);
        chk("cnt3.err", 32'(err_count), 32'd7);

        // Clear coinciding with a handshake must win.
        req(7'h13, 1, 0, 0, 0, 0, 32'd7);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("clr.valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        chk("clr.inst", 32'(inst_count), 32'd0);
        chk("clr.err", 32'(err_count), 32'd0);

        out_ready = 1'b0;
        req(7'h13, 1, 0, 0, 0, 0, 32'd1);
        chk("bp.a_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        req(7'h13, 1, 0, 0, 0, 0, 32'd2);
        chk("bp.b_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        req(7'h13, 1, 0, 0, 0, 0, 32'd3);
        chk("bp.stall_valid", 32'(out_valid), 32'd1);
        chk("bp.stall_inst", out_inst, 32'h0010_0093);
        chk("bp.c_blocked", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp.hold_inst", out_inst, 32'h0010_0093);
        chk("bp.hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk("bp.b_inst", out_inst, 32'h0020_0093);
        chk("bp.b_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp.c_inst", out_inst, 32'h0030_0093);
        chk("bp.c_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp.drained", 32'(out_valid), 32'd0);
        chk("bp.count", 32'(inst_count), 32'd3);

        out_ready = 1'b0;
        req(7'h13, 1, 0, 0, 0, 0, 32'd9);
        @(negedge clk);
        req(7'h13, 1, 0, 0, 0, 0, 32'd10);
        @(negedge clk); in_valid = 1'b0;
        chk("ar.full_valid", 32'(out_valid), 32'd1);
        chk("ar.full_ready", 32'(in_ready), 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk("ar.valid", 32'(out_valid), 32'd0);
        chk("ar.inst_count", 32'(inst_count), 32'd0);
        chk("ar.err_count", 32'(err_count), 32'd0);
        chk("ar.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rstn = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ar.no_stale", 32'(out_valid), 32'd0);
        end
        chk("ar.count_after", 32'(inst_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
